// File: rtl/monitor_cluster_sequencer_if.sv
// monitor_cluster_sequencer_if: upstream trace-symbol handshake (valid/ready with last marker).
interface monitor_cluster_sequencer_if #(
    parameter int SYM_W = 8
);
    logic             sym_valid;
    logic [SYM_W-1:0] sym_data;
    logic             sym_last;
    logic             sym_ready;
    modport master (output sym_valid, sym_data, sym_last, input sym_ready);
    modport slave  (input sym_valid, sym_data, sym_last, output sym_ready);
endinterface

// File: rtl/monitor_cluster_sequencer.sv
// monitor_cluster_sequencer: clears, feeds and watches one monitor cluster; MON_SEQ_HALT_ON_VIOL_EN stops the stream on first violation.
module monitor_cluster_sequencer #(
    parameter int NUM_PROPS = 13,
    parameter int SYM_W     = 8,
    parameter int PIPE_LAT  = 2,
    parameter int RST_CYC   = 2,
    parameter int CNT_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    monitor_cluster_sequencer_if.slave   sym,
    output logic                         mon_reset,
    output logic                         mon_run,
    output logic [SYM_W-1:0]             mon_symbols,
    input  logic [NUM_PROPS-1:0]         ltl_hits,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_PROPS-1:0]         viol_sticky,
    output logic                         viol_any,
    output logic [$clog2(NUM_PROPS)-1:0] first_viol_idx,
    output logic [CNT_W-1:0]             first_viol_cnt,
    output logic [CNT_W-1:0]             sym_count
);
    localparam int IDX_W = $clog2(NUM_PROPS);
    localparam logic [7:0] CLR_LAST   = 8'(RST_CYC - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(PIPE_LAT - 1);
    typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, DONE} state_t;
    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 mon_reset_q, mon_reset_d, mon_run_q, mon_run_d;
    logic [SYM_W-1:0]     mon_symbols_q, mon_symbols_d;
    logic [NUM_PROPS-1:0] viol_sticky_q, viol_sticky_d, sampled;
    logic [IDX_W-1:0]     first_idx_q, first_idx_d, low_idx;
    logic [CNT_W-1:0]     first_cnt_q, first_cnt_d, sym_count_q, sym_count_d;
    logic                 xfer, first_hit, halt, enter_clr;
    always_comb begin
        low_idx = '0;
        for (int i = NUM_PROPS - 1; i >= 0; i--) if (ltl_hits[i]) low_idx = IDX_W'(i);
        xfer      = sym.sym_valid && state_q == STREAM && !abort;
        sampled   = (state_q == STREAM || state_q == DRAIN) ? ltl_hits : '0;
        first_hit = |sampled && !(|viol_sticky_q);
`ifdef MON_SEQ_HALT_ON_VIOL_EN
        halt = first_hit && state_q == STREAM;
`else
        halt = 1'b0;
`endif
        state_d = state_q;
        if (abort) state_d = IDLE;
        else if ((state_q == IDLE || state_q == DONE) && start) state_d = CLR;
        else if (state_q == CLR && cnt_q == CLR_LAST) state_d = STREAM;
        else if (state_q == STREAM && ((xfer && sym.sym_last) || halt)) state_d = DRAIN;
        else if (state_q == DRAIN && cnt_q == DRAIN_LAST) state_d = DONE;
        // cnt times the CLR and DRAIN dwell; it restarts on every state change
        cnt_d         = state_d == state_q ? cnt_q + 8'd1 : 8'd0;
        enter_clr     = state_d == CLR && state_q != CLR;
        mon_reset_d   = abort || state_d == CLR;
        mon_run_d     = xfer;
        mon_symbols_d = xfer ? sym.sym_data : mon_symbols_q;
        sym_count_d   = enter_clr ? '0 : (xfer && !(&sym_count_q)) ? sym_count_q + CNT_W'(1) : sym_count_q;
        viol_sticky_d = enter_clr ? '0 : viol_sticky_q | sampled;
        first_idx_d   = enter_clr ? '0 : first_hit ? low_idx : first_idx_q;
        first_cnt_d   = enter_clr ? '0 : first_hit ? sym_count_q : first_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mon_reset_q   <= 1'b0;
            mon_run_q     <= 1'b0;
            mon_symbols_q <= '0;
            viol_sticky_q <= '0;
            first_idx_q   <= '0;
            first_cnt_q   <= '0;
            sym_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mon_reset_q   <= mon_reset_d;
            mon_run_q     <= mon_run_d;
            mon_symbols_q <= mon_symbols_d;
            viol_sticky_q <= viol_sticky_d;
            first_idx_q   <= first_idx_d;
            first_cnt_q   <= first_cnt_d;
            sym_count_q   <= sym_count_d;
        end
    end
    assign sym.sym_ready   = state_q == STREAM;
    assign busy            = state_q == CLR || state_q == STREAM || state_q == DRAIN;
    assign done            = state_q == DONE;
    assign mon_reset       = mon_reset_q;
    assign mon_run         = mon_run_q;
    assign mon_symbols     = mon_symbols_q;
    assign viol_sticky     = viol_sticky_q;
    assign viol_any        = |viol_sticky_q;
    assign first_viol_idx  = first_idx_q;
    assign first_viol_cnt  = first_cnt_q;
    assign sym_count       = sym_count_q;
endmodule

// File: tb/tb_monitor_cluster_sequencer.sv
// tb_monitor_cluster_sequencer: directed streams against a phase/timeline model plus literal expectations.
module tb_monitor_cluster_sequencer;
    localparam int NP = 13, SW = 8, PL = 2, RC = 2, CW = 32;
    localparam int P_IDLE = 0, P_CLR = 1, P_STR = 2, P_DRN = 3, P_DONE = 4;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [NP-1:0] ltl_hits, inj = '0, hit_pipe = '0;
    logic mon_reset, mon_run, busy, done, viol_any;
    logic [SW-1:0] mon_symbols;
    logic [NP-1:0] viol_sticky;
    logic [3:0] first_viol_idx;
    logic [CW-1:0] first_viol_cnt, sym_count;
    logic [7:0] ta_sym = 8'h00, tb_sym = 8'h00;
    logic [NP-1:0] ta_val = '0, tb_val = '0;
    int checks = 0, failures = 0, n_rst = 0, n_run = 0;
    bit stopped;
    monitor_cluster_sequencer_if #(.SYM_W(SW)) sif ();
    monitor_cluster_sequencer #(.NUM_PROPS(NP), .SYM_W(SW), .PIPE_LAT(PL), .RST_CYC(RC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sym(sif),
        .mon_reset(mon_reset), .mon_run(mon_run), .mon_symbols(mon_symbols), .ltl_hits(ltl_hits),
        .busy(busy), .done(done), .viol_sticky(viol_sticky), .viol_any(viol_any),
        .first_viol_idx(first_viol_idx), .first_viol_cnt(first_viol_cnt), .sym_count(sym_count));
    always #5 clk = ~clk;
    // Stand-in cluster: symbols matching a trigger raise flags PIPE_LAT cycles after their transfer
    function automatic logic [NP-1:0] cmap(logic [7:0] s);
        return (s == ta_sym ? ta_val : '0) | (s == tb_sym ? tb_val : '0);
    endfunction
    always @(posedge clk) hit_pipe <= mon_run ? cmap(mon_symbols) : '0;
    assign ltl_hits = hit_pipe | inj;
    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    int m_ph = P_IDLE, m_left = 0;
    logic m_rst = 0, m_run = 0;
    logic [SW-1:0] m_sym = '0;
    logic [NP-1:0] m_sticky = '0;
    logic [3:0] m_fidx = '0;
    logic [CW-1:0] m_fcnt = '0, m_cnt = '0;
    bit live = 0;
    always @(posedge clk) begin : model
        bit xf, first;
        logic [NP-1:0] h;
        if (reset) begin
            live = 1; m_ph = P_IDLE; m_rst = 0; m_run = 0; m_sym = '0;
            m_sticky = '0; m_fidx = '0; m_fcnt = '0; m_cnt = '0;
        end else begin
            xf = sif.sym_valid && m_ph == P_STR && !abort;
            h = (m_ph == P_STR || m_ph == P_DRN) ? ltl_hits : '0;
            first = h != 0 && m_sticky == 0;
            if (first) begin
                m_fcnt = m_cnt;
                for (int i = NP - 1; i >= 0; i--) if (h[i]) m_fidx = 4'(i);
            end
            m_sticky |= h;
            m_run = xf;
            if (xf) begin
                m_sym = sif.sym_data;
                if (m_cnt != '1) m_cnt++;
            end
`ifdef MON_SEQ_HALT_ON_VIOL_EN
            first = first && m_ph == P_STR;
`else
            first = 0;
`endif
            if (abort) m_ph = P_IDLE;
            else if ((m_ph == P_IDLE || m_ph == P_DONE) && start) begin
                m_ph = P_CLR; m_left = RC; m_sticky = '0; m_fidx = '0; m_fcnt = '0; m_cnt = '0;
            end else if (m_ph == P_CLR) begin
                m_left--;
                if (m_left == 0) m_ph = P_STR;
            end else if (m_ph == P_STR && ((xf && sif.sym_last) || first)) begin
                m_ph = P_DRN; m_left = PL;
            end else if (m_ph == P_DRN) begin
                m_left--;
                if (m_left == 0) m_ph = P_DONE;
            end
            m_rst = abort || m_ph == P_CLR;
        end
    end
    always @(negedge clk) if (live) begin
        n_rst += int'(mon_reset);
        n_run += int'(mon_run);
        chk("mon_reset", mon_reset, m_rst);
        chk("mon_run", mon_run, m_run);
        chk("mon_symbols", mon_symbols, m_sym);
        chk("sym_ready", sif.sym_ready, m_ph == P_STR);
        chk("busy", busy, m_ph == P_CLR || m_ph == P_STR || m_ph == P_DRN);
        chk("done", done, m_ph == P_DONE);
        chk("viol_sticky", viol_sticky, m_sticky);
        chk("viol_any", viol_any, |m_sticky);
        chk("first_viol_idx", first_viol_idx, m_fidx);
        chk("first_viol_cnt", first_viol_cnt, m_fcnt);
        chk("sym_count", sym_count, m_cnt);
    end
    task automatic pulse_start();
        start = 1; @(posedge clk); #1 start = 0;
    endtask
    task automatic send(input logic [7:0] d, input bit last, input int gap, input bit may_stop, output bit stop);
        int n = 0;
        stop = 0;
        sif.sym_valid = 1; sif.sym_data = d; sif.sym_last = last;
        @(negedge clk);
        while (!sif.sym_ready) begin
            n++;
            if (n > 30) begin
                if (!may_stop) begin
                    checks++; failures++;
                    $display("FAIL send_timeout: got sym_ready=0 expected 1 for symbol %0h", d);
                end
                stop = 1; sif.sym_valid = 0; sif.sym_last = 0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1 sif.sym_valid = 0; sif.sym_last = 0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask
    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        chk("wait_done", done, 1);
    endtask
    initial begin
        int br, bn;
        sif.sym_valid = 0; sif.sym_data = '0; sif.sym_last = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_count", sym_count, 0); chk("rst_mon_reset", mon_reset, 0);
        @(posedge clk); #1;
        br = n_rst; bn = n_run;
        pulse_start();
        send(8'h11, 0, 0, 0, stopped); send(8'h22, 0, 0, 0, stopped); send(8'h33, 1, 0, 0, stopped);
        wait_done();
        chk("t1_count", sym_count, 3); chk("t1_viol", viol_any, 0);
        chk("t1_reset_cycles", n_rst - br, 2); chk("t1_run_cycles", n_run - bn, 3);
        @(posedge clk); #1 inj = '1;
        repeat (2) @(posedge clk);
        #1 inj = '0;
        @(negedge clk) chk("done_hits_ignored", viol_any, 0);
        @(posedge clk); #1;
        ta_sym = 8'h43; ta_val = 13'h0110; tb_sym = 8'h45; tb_val = 13'h0001;
        pulse_start();
        send(8'h41, 0, 0, 0, stopped); send(8'h42, 0, 0, 0, stopped); send(8'h43, 0, 3, 0, stopped);
        chk("t2_sticky_mid", viol_sticky, 13'h0110); chk("t2_idx", first_viol_idx, 4); chk("t2_cnt", first_viol_cnt, 3);
        send(8'h44, 0, 0, 0, stopped); send(8'h45, 1, 0, 0, stopped);
        wait_done();
        chk("t3_sticky", viol_sticky, 13'h0111); chk("t3_idx", first_viol_idx, 4); chk("t3_cnt", first_viol_cnt, 3);
        @(posedge clk); #1 ta_val = '0; tb_val = '0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send(8'h60 + 8'(i), i == 5, 1, 0, stopped);
            if (i == 2) pulse_start();
        end
        wait_done();
        chk("t4_count", sym_count, 6); chk("t4_cleared", viol_any, 0); chk("t4_last_sym", mon_symbols, 8'h65);
        @(posedge clk); #1 ta_sym = 8'h51; ta_val = 13'h0002;
        pulse_start();
        send(8'h51, 0, 3, 0, stopped); send(8'h52, 0, 0, 0, stopped);
        chk("t5_viol_pre", viol_any, 1);
        abort = 1; @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("t5_abort_rst", mon_reset, 1); chk("t5_abort_busy", busy, 0); chk("t5_abort_ready", sif.sym_ready, 0);
        @(negedge clk) chk("t5_abort_rst_pulse", mon_reset, 0);
        @(posedge clk); #1 start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        @(negedge clk) chk("t5_start_abort_idle", busy, 0); chk("t5_status_held", viol_any, 1);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk) chk("t5_clr_viol", viol_any, 0); chk("t5_clr_count", sym_count, 0); chk("t5_clr_rst", mon_reset, 1);
        @(posedge clk); #1;
        send(8'h53, 1, 0, 0, stopped);
        wait_done();
        ta_sym = 8'h72; ta_val = 13'h0004;
        pulse_start();
        for (int i = 1; i <= 10; i++) begin
            send(8'h70 + 8'(i), i == 10, 0, 1, stopped);
            if (stopped) break;
        end
        wait_done();
        chk("t6_viol", viol_sticky, 13'h0004);
`ifdef MON_SEQ_HALT_ON_VIOL_EN
        chk("t6_halt_count", sym_count <= 4, 1); chk("t6_halt_ready", sif.sym_ready, 0);
`else
        chk("t6_full_count", sym_count, 10);
`endif
        @(posedge clk); #1 ta_val = '0;
        pulse_start();
        send(8'h81, 0, 0, 0, stopped); send(8'h82, 0, 0, 0, stopped);
        reset = 1; @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t7_busy", busy, 0); chk("t7_count", sym_count, 0); chk("t7_sym", mon_symbols, 0); chk("t7_run", mon_run, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
